// File: rtl/adc0804_reader.sv
// ADC0804 host controller: periodic conversion start, INTR wait, byte read.
// Registered strobes, one-cycle sample_valid / timeout pulses.
module adc0804_reader #(
  parameter int SAMPLE_PERIOD  = 25_000,
  parameter int WR_CYCLES      = 4,
  parameter int RD_CYCLES      = 6,
  parameter int TIMEOUT_CYCLES = 5_000
) (
  input  logic       clock_25mhz,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] adc_data,
  input  logic       adc_intr_n,
  output logic       adc_cs_n,
  output logic       adc_wr_n,
  output logic       adc_rd_n,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic       timeout
);

  localparam int PW =
    (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SMAX =
    (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int SW = (SMAX > 1) ? $clog2(SMAX) : 1;

  localparam logic [PW-1:0] P_LAST  = PW'(SAMPLE_PERIOD - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] WR_LAST = SW'(WR_CYCLES - 1);
  localparam logic [SW-1:0] RD_LAST = SW'(RD_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic [2:0]    state;
  logic [PW-1:0] period_cnt;
  logic [TW-1:0] wait_cnt;
  logic [SW-1:0] stb_cnt;
  logic          intr_meta;
  logic          sync_intr_n;

  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      intr_meta   <= 1'b1;
      sync_intr_n <= 1'b1;
    end else begin
      intr_meta   <= adc_intr_n;
      sync_intr_n <= intr_meta;
    end
  end

  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      period_cnt   <= '0;
      wait_cnt     <= '0;
      stb_cnt      <= '0;
      adc_cs_n     <= 1'b1;
      adc_wr_n     <= 1'b1;
      adc_rd_n     <= 1'b1;
      sample       <= 8'h00;
      sample_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      timeout      <= 1'b0;
      // Saturating so a long stall never wraps into an early restart
      if (period_cnt != '1)
        period_cnt <= period_cnt + 1'b1;

      unique case (state)
        S_IDLE: begin
          if (enable) begin
            state      <= S_START;
            adc_cs_n   <= 1'b0;
            adc_wr_n   <= 1'b0;
            stb_cnt    <= '0;
            period_cnt <= '0;
          end
        end
        S_START: begin
          stb_cnt <= stb_cnt + 1'b1;
          if (stb_cnt == WR_LAST) begin
            state    <= S_WAIT;
            adc_cs_n <= 1'b1;
            adc_wr_n <= 1'b1;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (!sync_intr_n) begin
            state    <= S_READ;
            adc_cs_n <= 1'b0;
            adc_rd_n <= 1'b0;
            stb_cnt  <= '0;
          end else if (wait_cnt == T_LAST) begin
            state   <= S_HOLD;
            timeout <= 1'b1;
          end
        end
        S_READ: begin
          stb_cnt <= stb_cnt + 1'b1;
          if (stb_cnt == RD_LAST) begin
            state        <= S_HOLD;
            adc_cs_n     <= 1'b1;
            adc_rd_n     <= 1'b1;
            sample       <= adc_data;
            sample_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (period_cnt >= P_LAST) begin
            if (enable) begin
              state      <= S_START;
              adc_cs_n   <= 1'b0;
              adc_wr_n   <= 1'b0;
              stb_cnt    <= '0;
              period_cnt <= '0;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc0804_reader.sv
// Bench for adc0804_reader: three parameterisations, behavioural ADC model,
// timing checked against conversion timeline arithmetic.
module tb_adc0804_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en [3];
  logic [7:0] din [3] = '{default: 8'h00};
  logic       intr_n [3] = '{default: 1'b1};
  logic       cs_n [3], wr_n [3], rd_n [3], vld [3], tmo [3];
  logic [7:0] smp [3];

  logic a_cs, a_wr, a_rd, a_v, a_t;
  logic b_cs, b_wr, b_rd, b_v, b_t;
  logic c_cs, c_wr, c_rd, c_v, c_t;
  logic [7:0] a_s, b_s, c_s;

  int         dly [3];
  bit         glitch [3];
  bit         rnd [3];
  logic [7:0] fix [3];
  logic [7:0] exp_smp [3];
  logic [7:0] last_rd [3] = '{default: 8'h00};
  int         rem [3] = '{default: 0};
  logic       wr_q [3] = '{default: 1'b1};
  bit         gclr [3] = '{default: 1'b0};

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    cs_n[0] = a_cs; wr_n[0] = a_wr; rd_n[0] = a_rd;
    vld[0] = a_v; tmo[0] = a_t; smp[0] = a_s;
    cs_n[1] = b_cs; wr_n[1] = b_wr; rd_n[1] = b_rd;
    vld[1] = b_v; tmo[1] = b_t; smp[1] = b_s;
    cs_n[2] = c_cs; wr_n[2] = c_wr; rd_n[2] = c_rd;
    vld[2] = c_v; tmo[2] = c_t; smp[2] = c_s;
  end

  adc0804_reader #(
    .SAMPLE_PERIOD(25_000), .WR_CYCLES(4),
    .RD_CYCLES(6), .TIMEOUT_CYCLES(5_000)
  ) u_a (
    .clock_25mhz(clk), .reset_n(rst_n), .enable(en[0]),
    .adc_data(din[0]), .adc_intr_n(intr_n[0]),
    .adc_cs_n(a_cs), .adc_wr_n(a_wr), .adc_rd_n(a_rd),
    .sample(a_s), .sample_valid(a_v), .timeout(a_t)
  );

  adc0804_reader #(
    .SAMPLE_PERIOD(30), .WR_CYCLES(4),
    .RD_CYCLES(6), .TIMEOUT_CYCLES(30)
  ) u_b (
    .clock_25mhz(clk), .reset_n(rst_n), .enable(en[1]),
    .adc_data(din[1]), .adc_intr_n(intr_n[1]),
    .adc_cs_n(b_cs), .adc_wr_n(b_wr), .adc_rd_n(b_rd),
    .sample(b_s), .sample_valid(b_v), .timeout(b_t)
  );

  adc0804_reader #(
    .SAMPLE_PERIOD(8), .WR_CYCLES(4),
    .RD_CYCLES(6), .TIMEOUT_CYCLES(5_000)
  ) u_c (
    .clock_25mhz(clk), .reset_n(rst_n), .enable(en[2]),
    .adc_data(din[2]), .adc_intr_n(intr_n[2]),
    .adc_cs_n(c_cs), .adc_wr_n(c_wr), .adc_rd_n(c_rd),
    .sample(c_s), .sample_valid(c_v), .timeout(c_t)
  );

  function automatic int sp(input int i);
    case (i)
      0: return 25_000;
      1: return 30;
      default: return 8;
    endcase
  endfunction

  function automatic int tm(input int i);
    return (i == 1) ? 30 : 5_000;
  endfunction

  // ADC model: INTR falls dly clocks after WR rises, clears when RD is low
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        intr_n[i] = 1'b1;
        rem[i]    = 0;
        gclr[i]   = 1'b0;
        wr_q[i]   = 1'b1;
      end else begin
        if (gclr[i]) begin
          intr_n[i] = 1'b1;
          gclr[i]   = 1'b0;
        end
        if (!wr_q[i] && wr_n[i] && dly[i] > 0) begin
          rem[i] = dly[i];
        end else if (rem[i] > 0) begin
          rem[i] = rem[i] - 1;
          if (rem[i] == 0) begin
            intr_n[i] = 1'b0;
            gclr[i]   = glitch[i];
          end
        end
        if (!rd_n[i]) intr_n[i] = 1'b1;
        if (!rnd[i]) din[i] = fix[i];
        else if (!rd_n[i]) din[i] = 8'($urandom);
        if (!rd_n[i]) last_rd[i] = din[i];
        wr_q[i] = wr_n[i];
      end
    end
  end

  // Observe one conversion; d<=0 means INTR never arrives
  task automatic conv(input int i, input int d,
                      input logic [7:0] exp_d, input bit use_last,
                      input int drop, output int s, output int e);
    int n, r, t;
    logic [7:0] want;
    dly[i] = d;
    s = -1; e = -1; n = -1;
    for (int k = 0; k < sp(i) + tm(i) + 64 && s < 0; k++) begin
      if (!wr_n[i]) s = cyc;
      else @(negedge clk);
    end
    n_chk++;
    if (s < 0) begin
      n_fail++;
      $display("FAIL start[%0d]: no wr_n fall seen", i);
      return;
    end
    for (int k = 0; k < 64 && n < 0; k++) begin
      @(negedge clk);
      if (wr_n[i] && cs_n[i]) n = cyc;
    end
    n_chk++;
    if (n - s != 4) begin
      n_fail++;
      $display("FAIL wr_len[%0d]: got %0d want 4", i, n - s);
      return;
    end
    r = -1; t = -1;
    for (int k = 0; k < tm(i) + 16 && r < 0 && t < 0; k++) begin
      @(negedge clk);
      if (k == drop) en[i] = 1'b0;
      if (!rd_n[i]) r = cyc;
      if (tmo[i]) t = cyc;
    end
    if (d > 0) begin
      n_chk++;
      if (r != n + d + 3 || t >= 0) begin
        n_fail++;
        $display("FAIL rd_start[%0d]: got %0d want %0d (tmo %0d)",
                 i, r - n, d + 3, t);
        return;
      end
      for (int k = 0; k < 32 && e < 0; k++) begin
        @(negedge clk);
        if (rd_n[i]) e = cyc;
      end
      n_chk++;
      if (e - r != 6) begin
        n_fail++;
        $display("FAIL rd_len[%0d]: got %0d want 6", i, e - r);
        return;
      end
      want = use_last ? last_rd[i] : exp_d;
      n_chk++;
      if (vld[i] !== 1'b1 || cs_n[i] !== 1'b1 || smp[i] !== want) begin
        n_fail++;
        $display("FAIL capture[%0d]: vld %b sample %h want 1/%h",
                 i, vld[i], smp[i], want);
      end
      exp_smp[i] = want;
    end else begin
      n_chk++;
      if (t != n + tm(i) || r >= 0) begin
        n_fail++;
        $display("FAIL timeout_at[%0d]: got %0d want %0d rd %0d",
                 i, t - n, tm(i), r);
        return;
      end
      e = t;
      n_chk++;
      if (smp[i] !== exp_smp[i] || vld[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_keep[%0d]: sample %h vld %b want %h/0",
                 i, smp[i], vld[i], exp_smp[i]);
      end
    end
    @(negedge clk);
    n_chk++;
    if (vld[i] !== 1'b0 || tmo[i] !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_len[%0d]: vld %b tmo %b want 0/0",
               i, vld[i], tmo[i]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({cs_n[i], wr_n[i], rd_n[i]} !== 3'b111 || smp[i] !== 8'h00
          || vld[i] !== 1'b0 || tmo[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: strobes %b%b%b sample %h want 111/00",
                 i, cs_n[i], wr_n[i], rd_n[i], smp[i]);
      end
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({cs_n[i], wr_n[i], rd_n[i]} !== 3'b111) begin
        n_fail++;
        $display("FAIL idle[%0d]: strobes %b%b%b want 111",
                 i, cs_n[i], wr_n[i], rd_n[i]);
      end
    end
  endtask

  int s_nom;

  task automatic test_nominal();
    int s, e, k;
    fix[0] = 8'hA5;
    en[0] = 1'b1;
    k = cyc;
    conv(0, 50, 8'hA5, 1'b0, -1, s, e);
    n_chk++;
    if (s != k + 1) begin
      n_fail++;
      $display("FAIL idle_start: got %0d want %0d", s - k, 1);
    end
    s_nom = s;
  endtask

  task automatic test_timeout();
    int s, e, s3;
    fix[0] = 8'h00;
    conv(0, -1, 8'h00, 1'b0, -1, s, e);
    n_chk++;
    if (s != s_nom + 25_000) begin
      n_fail++;
      $display("FAIL period_nom: got %0d want 25000", s - s_nom);
    end
    fix[0] = 8'hA5;
    dly[0] = 50;
    s3 = -1;
    for (int k = 0; k < 26_000 && s3 < 0; k++) begin
      @(negedge clk);
      if (!wr_n[0]) s3 = cyc;
    end
    n_chk++;
    if (s3 != s + 25_000) begin
      n_fail++;
      $display("FAIL period_after_timeout: got %0d want 25000", s3 - s);
    end
    en[0] = 1'b0;
  endtask

  task automatic test_random();
    int s, e, ps, pe, d, want;
    rnd[1] = 1'b1;
    en[1] = 1'b1;
    ps = 0; pe = 0;
    for (int j = 0; j < 12; j++) begin
      d = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 26));
      conv(1, d, 8'h00, 1'b1, -1, s, e);
      if (j > 0) begin
        want = (ps + 30 > pe + 1) ? ps + 30 : pe + 1;
        n_chk++;
        if (s != want) begin
          n_fail++;
          $display("FAIL spacing[%0d]: got %0d want %0d", j, s - ps, want - ps);
        end
      end
      ps = s; pe = e;
    end
  endtask

  task automatic test_enable_drop();
    int s, e, starts, pulses;
    conv(1, 15, 8'h00, 1'b1, 3, s, e);
    starts = 0; pulses = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!wr_n[1]) starts++;
      if (vld[1]) pulses++;
    end
    n_chk++;
    if (starts != 0 || pulses != 0) begin
      n_fail++;
      $display("FAIL enable_drop: wr_low %0d valid %0d want 0/0",
               starts, pulses);
    end
  endtask

  task automatic test_glitch();
    int s, e, k;
    glitch[1] = 1'b1;
    en[1] = 1'b1;
    k = cyc;
    conv(1, 10, 8'h00, 1'b1, -1, s, e);
    n_chk++;
    if (s != k + 1) begin
      n_fail++;
      $display("FAIL reenable_start: got %0d want 1", s - k);
    end
    glitch[1] = 1'b0;
  endtask

  task automatic test_back_to_back();
    int s, e, ps, pe, k;
    logic [7:0] v;
    en[2] = 1'b1;
    k = cyc;
    pe = k;
    for (int j = 0; j < 5; j++) begin
      v = 8'($urandom);
      fix[2] = v;
      conv(2, 16, v, 1'b0, -1, s, e);
      n_chk++;
      if (s != pe + 1) begin
        n_fail++;
        $display("FAIL hold_len[%0d]: got %0d want 1", j, s - pe);
      end
      ps = s; pe = e;
    end
    en[2] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int r, pulses;
    rnd[1] = 1'b1;
    dly[1] = 5;
    en[1] = 1'b1;
    r = -1;
    for (int k = 0; k < 200 && r < 0; k++) begin
      @(negedge clk);
      if (!rd_n[1]) r = cyc;
    end
    n_chk++;
    if (r < 0) begin
      n_fail++;
      $display("FAIL reset_mid_read: rd_n never low");
    end
    #5;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({cs_n[1], wr_n[1], rd_n[1]} !== 3'b111 || smp[1] !== 8'h00
        || vld[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: strobes %b%b%b sample %h vld %b want 111/00/0",
               cs_n[1], wr_n[1], rd_n[1], smp[1], vld[1]);
    end
    en[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (vld[1] || !rd_n[1]) pulses++;
    end
    n_chk++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL reset_mid_after: activity %0d want 0", pulses);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0;
      dly[i] = -1;
      glitch[i] = 1'b0;
      rnd[i] = 1'b0;
      fix[i] = 8'h00;
      exp_smp[i] = 8'h00;
    end
    test_reset();
    test_nominal();
    test_timeout();
    test_random();
    test_enable_drop();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
